det_event_logger: RTL and testbench
===================================

# det_event_logger

Downstream consumer of the serial pattern detector's one-cycle match pulse. It counts matches, raises a threshold interrupt and records a timestamp for every match in a small FIFO. Software or a downstream reader drains the FIFO over a valid/ready handshake. It sits between the detector output and the status/register layer.

## Interface
Parameters:
- CNT_W, 16: width of match counter and threshold.
- TS_W, 16: width of free-running timestamp counter and FIFO entries.
- DEPTH, 4: timestamp FIFO depth; power of two, at least 2.

Ports:
- clk  input  1  sole clock, rising edge.
- rstn  input  1  reset, asynchronous assert, active-low. All state clears immediately when low.
- det_in  input  1  match pulse from the detector; each cycle high is one event.
- clr  input  1  synchronous clear of counters, flags and FIFO.
- thresh  input  CNT_W  interrupt threshold; 0 disables irq.
- match_cnt  output  CNT_W  number of events since reset/clr, saturating.
- cnt_sat  output  1  sticky; match_cnt has reached all-ones.
- irq  output  1  sticky level; count reached thresh.
- ts_data  output  TS_W  timestamp at FIFO head; valid only while ts_valid=1.
- ts_valid  output  1  FIFO not empty.
- ts_ready  input  1  reader accepts head this cycle.
- ts_level  output  clog2(DEPTH)+1  current FIFO occupancy.
- ts_drop  output  1  sticky; an event was lost because the FIFO was full.

## Operation
- Timestamp counter ts_now (TS_W bits):
  - 0 in the first cycle after rstn deasserts, then +1 every cycle.
  - Wraps from all-ones to 0.
  - Not affected by clr.
- Event cycle: det_in=1 and clr=0.
  - match_cnt increments by 1.
  - If match_cnt is all-ones it holds, and cnt_sat sets.
- irq:
  - Sets when thresh≠0 and an event makes the next match_cnt equal to thresh.
  - Stays set until clr or reset, even if thresh changes.
  - Saturation never sets irq unless the count equals thresh.
- FIFO push: every event cycle writes ts_now (the value in that same cycle) to the tail.
  - If full with no pop in the same cycle, the entry is discarded, ts_drop sets, and FIFO contents are unchanged.
- FIFO pop: when ts_valid=1 and ts_ready=1, the head is removed. ts_ready while empty is ignored.
- Push and pop in the same cycle:
  - Full: both take effect; level stays DEPTH; no drop.
  - Empty: only the push takes effect, since ts_valid was 0.
- clr=1:
  - match_cnt, cnt_sat, irq and ts_drop go to 0.
  - FIFO is flushed: pointers 0, level 0.
  - Any det_in or pop in the same cycle is ignored; clr wins.
- Reset values: match_cnt=0, cnt_sat=0, irq=0, ts_valid=0, ts_level=0, ts_drop=0, ts_data=0. ts_now=0.
- FIFO storage: register array; read and write pointers are clog2(DEPTH)+1 bits, wrap-bit scheme. ts_data is read combinationally from the head entry.

## Timing
- All state updates on the rising edge of clk.
- Event-to-output latency is 1 cycle for match_cnt, cnt_sat, irq and ts_level.
- ts_valid rises the cycle after a push into an empty FIFO.
- After a pop, the next entry is presented on ts_data in the following cycle. Back-to-back pops sustain one entry per cycle.
- ts_data and ts_valid stay stable while ts_valid=1 and ts_ready=0.
- The interface accepts det_in on consecutive cycles; every high cycle is counted and pushed.
- rstn assertion mid-operation clears everything asynchronously. The first event can be counted on the first rising edge with rstn high.

## Test plan
- Basic count: reset, thresh=3, det_in pulses at ts_now=5, 9, 12 -> match_cnt steps 1,2,3; irq rises with the third update; FIFO pops return 5, 9, 12 in order; ts_valid then falls.
- Overflow: DEPTH=4, ts_ready=0, 5 pulses at ts_now=2,4,6,8,10 -> ts_level=4, ts_drop=1, pops return 2,4,6,8.
- Full simultaneous push/pop: fill to 4, then det_in=1 with ts_ready=1 at ts_now=20 -> head popped, 20 appended, ts_level stays 4, ts_drop stays 0.
- Saturation: CNT_W=4, thresh=0, 17 events -> match_cnt=15, cnt_sat=1 at the 15th, irq never sets.
- clr priority: clr=1 together with det_in=1 and ts_ready=1 on a non-empty FIFO -> next cycle match_cnt=0, irq=0, ts_drop=0, ts_valid=0, ts_level=0; ts_now continues counting.
- Async reset mid-stream: drop rstn between clock edges with FIFO holding 3 entries -> all outputs 0 immediately, without waiting for a clock edge; after release, ts_now restarts at 0.

Source files
------------

// File: rtl/det_event_logger.sv
// Match-event logger: saturating event counter, sticky threshold interrupt and a
// timestamp FIFO drained by a valid/ready reader. Timestamps come from a free-running counter.
module det_event_logger #(
    parameter int CNT_W = 16,
    parameter int TS_W  = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     det_in,
    input  logic                     clr,
    input  logic [CNT_W-1:0]         thresh,
    output logic [CNT_W-1:0]         match_cnt,
    output logic                     cnt_sat,
    output logic                     irq,
    output logic [TS_W-1:0]          ts_data,
    output logic                     ts_valid,
    input  logic                     ts_ready,
    output logic [$clog2(DEPTH):0]   ts_level,
    output logic                     ts_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [TS_W-1:0]  TS_ONE  = 1;

    logic [TS_W-1:0]  ts_now;
    logic [TS_W-1:0]  mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             ev;
    logic             pop;
    logic             push;
    logic             full;
    logic             cnt_max;
    logic [CNT_W-1:0] cnt_next;

    // clr masks both the event and the pop so a clearing cycle leaves nothing behind
    always_comb begin
        ev       = det_in & ~clr;
        full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop      = ts_valid & ts_ready & ~clr;
        push     = ev & (~full | pop);
        cnt_max  = &match_cnt;
        cnt_next = cnt_max ? match_cnt : match_cnt + CNT_ONE;
    end

    assign ts_valid = (wr_ptr != rd_ptr);
    assign ts_level = wr_ptr - rd_ptr;
    assign ts_data  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ts_now <= '0;
        end else begin
            ts_now <= ts_now + TS_ONE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
            irq       <= 1'b0;
        end else if (clr) begin
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
            irq       <= 1'b0;
        end else if (ev) begin
            match_cnt <= cnt_next;
            if (&cnt_next) begin
                cnt_sat <= 1'b1;
            end
            if ((thresh != '0) && (cnt_next == thresh)) begin
                irq <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ts_drop <= 1'b0;
        end else if (clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ts_drop <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (ev && !push) begin
                ts_drop <= 1'b1;
            end
        end
    end

    // Storage is reset so ts_data reads 0 out of reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr[AW-1:0]] <= ts_now;
        end
    end

endmodule

// File: tb/tb_det_event_logger.sv
// Directed bench for det_event_logger: default instance for counting/FIFO/clr/reset,
// a CNT_W=4 instance for saturation.
module tb_det_event_logger;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        det_in = 1'b0;
    logic        clr = 1'b0;
    logic        ts_ready = 1'b0;
    logic [15:0] thresh = '0;
    logic [15:0] match_cnt;
    logic        cnt_sat;
    logic        irq;
    logic [15:0] ts_data;
    logic        ts_valid;
    logic [2:0]  ts_level;
    logic        ts_drop;

    logic        det_s = 1'b0;
    logic [3:0]  thresh_s = '0;
    logic [3:0]  s_cnt;
    logic        s_sat;
    logic        s_irq;
    logic [15:0] s_data;
    logic        s_valid;
    logic [2:0]  s_level;
    logic        s_drop;

    int total = 0;
    int bad   = 0;
    int now   = 0;
    int k;

    always #5 clk = ~clk;

    det_event_logger u_dut (
        .clk(clk), .rstn(rstn), .det_in(det_in), .clr(clr), .thresh(thresh),
        .match_cnt(match_cnt), .cnt_sat(cnt_sat), .irq(irq), .ts_data(ts_data),
        .ts_valid(ts_valid), .ts_ready(ts_ready), .ts_level(ts_level), .ts_drop(ts_drop)
    );

    det_event_logger #(.CNT_W(4), .TS_W(16), .DEPTH(4)) u_sat (
        .clk(clk), .rstn(rstn), .det_in(det_s), .clr(clr), .thresh(thresh_s),
        .match_cnt(s_cnt), .cnt_sat(s_sat), .irq(s_irq), .ts_data(s_data),
        .ts_valid(s_valid), .ts_ready(1'b0), .ts_level(s_level), .ts_drop(s_drop)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // now = ts_now value sampled at the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
        if (rstn) now++;
    endtask

    task automatic run_to(input int n);
        while (now < n) tick();
    endtask

    task automatic pulse_at(input int n);
        run_to(n);
        det_in = 1'b1;
        tick();
        det_in = 1'b0;
    endtask

    task automatic do_reset();
        det_in = 1'b0; clr = 1'b0; ts_ready = 1'b0; det_s = 1'b0;
        rstn = 1'b0;
        #3;
        @(negedge clk);
        rstn = 1'b1;
        now = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // basic count and in-order drain
        do_reset();
        thresh = 16'd3;
        chk("rst_cnt", match_cnt, 0);
        chk("rst_sat", cnt_sat, 0);
        chk("rst_irq", irq, 0);
        chk("rst_valid", ts_valid, 0);
        chk("rst_level", ts_level, 0);
        chk("rst_drop", ts_drop, 0);
        chk("rst_data", ts_data, 0);
        pulse_at(5);
        chk("b1_cnt", match_cnt, 1);
        chk("b1_irq", irq, 0);
        chk("b1_valid", ts_valid, 1);
        chk("b1_data", ts_data, 5);
        pulse_at(9);
        chk("b2_cnt", match_cnt, 2);
        chk("b2_irq", irq, 0);
        chk("b2_level", ts_level, 2);
        chk("b2_head", ts_data, 5);
        pulse_at(12);
        chk("b3_cnt", match_cnt, 3);
        chk("b3_irq", irq, 1);
        chk("b3_level", ts_level, 3);
        tick(); tick();
        chk("b_hold_data", ts_data, 5);
        chk("b_hold_valid", ts_valid, 1);
        ts_ready = 1'b1;
        chk("b_pop0", ts_data, 5);
        tick();
        chk("b_pop1", ts_data, 9);
        tick();
        chk("b_pop2", ts_data, 12);
        tick();
        chk("b_empty_valid", ts_valid, 0);
        chk("b_empty_level", ts_level, 0);
        ts_ready = 1'b0;
        thresh = 16'd0;
        tick();
        chk("b_irq_sticky", irq, 1);

        // overflow
        do_reset();
        pulse_at(2); pulse_at(4); pulse_at(6); pulse_at(8);
        chk("o_level4", ts_level, 4);
        chk("o_nodrop", ts_drop, 0);
        pulse_at(10);
        chk("o_level_full", ts_level, 4);
        chk("o_drop", ts_drop, 1);
        chk("o_cnt", match_cnt, 5);
        ts_ready = 1'b1;
        chk("o_pop0", ts_data, 2); tick();
        chk("o_pop1", ts_data, 4); tick();
        chk("o_pop2", ts_data, 6); tick();
        chk("o_pop3", ts_data, 8); tick();
        chk("o_empty", ts_valid, 0);
        ts_ready = 1'b0;
        chk("o_drop_sticky", ts_drop, 1);

        // full with simultaneous push/pop, then push into empty with ready high
        do_reset();
        run_to(1);
        det_in = 1'b1;
        repeat (4) tick();
        det_in = 1'b0;
        chk("f_level", ts_level, 4);
        chk("f_cnt_b2b", match_cnt, 4);
        run_to(20);
        det_in = 1'b1; ts_ready = 1'b1;
        tick();
        det_in = 1'b0; ts_ready = 1'b0;
        chk("f_level_same", ts_level, 4);
        chk("f_nodrop", ts_drop, 0);
        chk("f_cnt", match_cnt, 5);
        ts_ready = 1'b1;
        chk("f_pop0", ts_data, 2); tick();
        chk("f_pop1", ts_data, 3); tick();
        chk("f_pop2", ts_data, 4); tick();
        chk("f_pop3", ts_data, 20); tick();
        chk("f_empty", ts_valid, 0);
        k = now;
        det_in = 1'b1;
        tick();
        det_in = 1'b0;
        chk("e_level", ts_level, 1);
        chk("e_valid", ts_valid, 1);
        chk("e_data", ts_data, k);
        tick();
        chk("e_drained", ts_level, 0);
        ts_ready = 1'b0;

        // saturation on the 4-bit instance
        thresh_s = 4'd0;
        det_s = 1'b1;
        repeat (14) tick();
        chk("s_cnt14", s_cnt, 14);
        chk("s_sat14", s_sat, 0);
        tick();
        chk("s_cnt15", s_cnt, 15);
        chk("s_sat15", s_sat, 1);
        tick(); tick();
        det_s = 1'b0;
        chk("s_cnt17", s_cnt, 15);
        chk("s_sat17", s_sat, 1);
        chk("s_irq", s_irq, 0);

        // clr priority
        do_reset();
        thresh = 16'd1;
        run_to(1);
        det_in = 1'b1;
        repeat (5) tick();
        det_in = 1'b0;
        chk("c_pre_cnt", match_cnt, 5);
        chk("c_pre_irq", irq, 1);
        chk("c_pre_drop", ts_drop, 1);
        clr = 1'b1; det_in = 1'b1; ts_ready = 1'b1;
        tick();
        clr = 1'b0; det_in = 1'b0; ts_ready = 1'b0;
        chk("c_cnt", match_cnt, 0);
        chk("c_irq", irq, 0);
        chk("c_drop", ts_drop, 0);
        chk("c_valid", ts_valid, 0);
        chk("c_level", ts_level, 0);
        k = now;
        det_in = 1'b1;
        tick();
        det_in = 1'b0;
        chk("c_ts_continues", ts_data, k);
        chk("c_post_cnt", match_cnt, 1);
        chk("c_post_irq", irq, 1);
        thresh = 16'd0;

        // async reset mid-stream
        do_reset();
        pulse_at(1); pulse_at(2); pulse_at(3);
        chk("a_level3", ts_level, 3);
        #2;
        rstn = 1'b0;
        #1;
        chk("a_cnt", match_cnt, 0);
        chk("a_irq", irq, 0);
        chk("a_sat", cnt_sat, 0);
        chk("a_valid", ts_valid, 0);
        chk("a_level", ts_level, 0);
        chk("a_drop", ts_drop, 0);
        chk("a_data", ts_data, 0);
        @(negedge clk);
        rstn = 1'b1;
        now = 0;
        det_in = 1'b1;
        tick();
        det_in = 1'b0;
        chk("a_first_cnt", match_cnt, 1);
        chk("a_first_ts", ts_data, 0);
        chk("a_first_level", ts_level, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
